// File: rtl/chk_pkg.sv
// Shared types for the output checker: FSM state encoding, checkpoint entry
// layout and the per-entry field mismatch counter.
package chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } chk_state_e;

   // Cycle field is stored 32 bits wide so the struct is independent of CYC_W;
   // writers zero-extend, so the upper bits stay zero.
   typedef struct packed {
      logic [31:0] cycle;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  c;
      logic        d;
   } chk_entry_t;

   function automatic logic [2:0] mism_cnt(input chk_entry_t e,
                                           input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] c,
                                           input logic       d);
      mism_cnt = {2'b00, (e.a != a)} + {2'b00, (e.b != b)}
               + {2'b00, (e.c != c)} + {2'b00, (e.d != d)};
   endfunction

endpackage

// File: rtl/chk_table.sv
// Checkpoint register file: one synchronous write port, one asynchronous read
// port; clears to zero on reset.
module chk_table
   import chk_pkg::*;
#(
   parameter  int NUM_CHK = 4,
   localparam int IDX_W   = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  chk_entry_t       wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output chk_entry_t       rd_data
);

   chk_entry_t mem_r [NUM_CHK];

   // Entry storage; out-of-range write indices are dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CHK; i++) begin
            mem_r[i] <= '0;
         end
      end else if (wr_en && (int'(wr_idx) < NUM_CHK)) begin
         mem_r[wr_idx] <= wr_data;
      end
   end

   assign rd_data = (int'(rd_idx) < NUM_CHK) ? mem_r[rd_idx] : '0;

endmodule

// File: rtl/out_checker.sv
// Checkpoint-based output checker: compares the upstream outputs against a
// table of expected values at programmed cycles and accumulates errors.
module out_checker
   import chk_pkg::*;
#(
   parameter  int NUM_CHK = 4,
   parameter  int CYC_W   = 16,
   parameter  int ERR_W   = 8,
   localparam int IDX_W   = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
   localparam int NUM_W   = IDX_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   input  logic [7:0]       c,
   input  logic             d,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [CYC_W-1:0] cfg_cycle,
   input  logic [7:0]       cfg_a,
   input  logic [7:0]       cfg_b,
   input  logic [7:0]       cfg_c,
   input  logic             cfg_d,
   input  logic [NUM_W-1:0] cfg_num,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [IDX_W-1:0] first_fail
);

   localparam int SUM_W = ERR_W + 1;

   chk_state_e       state_r, state_s;
   logic [CYC_W-1:0] cyc_r, cyc_s;
   logic [IDX_W-1:0] ptr_r, ptr_s;
   logic [NUM_W-1:0] num_r, num_s;
   logic [ERR_W-1:0] err_r, err_s;
   logic [IDX_W-1:0] ff_r, ff_s;
   logic             busy_r, done_r, pass_r;

   chk_entry_t       wr_entry_s;
   chk_entry_t       entry_s;
   logic             tbl_we_s;
   logic             due_s;
   logic [2:0]       mism_s;
   logic [SUM_W-1:0] sum_s;
   logic [ERR_W-1:0] err_sat_s;

   assign tbl_we_s   = cfg_we && (state_r != ST_RUN);
   assign wr_entry_s = '{cycle: 32'(cfg_cycle), a: cfg_a, b: cfg_b, c: cfg_c, d: cfg_d};

   chk_table #(.NUM_CHK(NUM_CHK)) u_table (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (tbl_we_s),
      .wr_idx  (cfg_idx),
      .wr_data (wr_entry_s),
      .rd_idx  (ptr_r),
      .rd_data (entry_s)
   );

   assign due_s     = (state_r == ST_RUN) && (NUM_W'(ptr_r) < num_r)
                      && (32'(cyc_r) >= entry_s.cycle);
   assign mism_s    = mism_cnt(entry_s, a, b, c, d);
   assign sum_s     = {1'b0, err_r} + SUM_W'(mism_s);
   assign err_sat_s = sum_s[ERR_W] ? {ERR_W{1'b1}} : sum_s[ERR_W-1:0];

   // Next-state, counter and error-accumulation logic.
   always_comb begin
      state_s = state_r;
      cyc_s   = cyc_r;
      ptr_s   = ptr_r;
      num_s   = num_r;
      err_s   = err_r;
      ff_s    = ff_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_s = ST_RUN;
               cyc_s   = '0;
               ptr_s   = '0;
               err_s   = '0;
               ff_s    = '0;
               num_s   = (cfg_num > NUM_W'(NUM_CHK)) ? NUM_W'(NUM_CHK) : cfg_num;
            end else begin
               state_s = state_r;
            end
         end
         ST_RUN: begin
            cyc_s = (cyc_r == {CYC_W{1'b1}}) ? cyc_r : cyc_r + CYC_W'(1);
            if (num_r == '0) begin
               state_s = ST_DONE;
            end else if (due_s) begin
               err_s = err_sat_s;
               // An error count of zero means no earlier entry has failed.
               if ((mism_s != 3'd0) && (err_r == '0)) begin
                  ff_s = ptr_r;
               end else begin
                  ff_s = ff_r;
               end
               if (NUM_W'(ptr_r) == (num_r - NUM_W'(1))) begin
                  state_s = ST_DONE;
               end else begin
                  ptr_s = ptr_r + IDX_W'(1);
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         cyc_r   <= '0;
         ptr_r   <= '0;
         num_r   <= '0;
         err_r   <= '0;
         ff_r    <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cyc_r   <= cyc_s;
         ptr_r   <= ptr_s;
         num_r   <= num_s;
         err_r   <= err_s;
         ff_r    <= ff_s;
         busy_r  <= (state_s == ST_RUN);
         done_r  <= (state_s == ST_DONE);
         pass_r  <= (state_s == ST_DONE) && (err_s == '0);
      end
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign pass       = pass_r;
   assign err_cnt    = err_r;
   assign first_fail = ff_r;

endmodule

// File: tb/tb_out_checker.sv
// Randomized self-checking bench for out_checker against a timeline-based
// reference model of checkpoint compare times and error totals.
module tb_out_checker;

   localparam int NUM_CHK = 4;
   localparam int CYC_W   = 6;
   localparam int ERR_W   = 4;
   localparam int IDX_W   = 2;
   localparam int NUM_W   = 3;
   localparam int STIM_N  = 128;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [7:0]       a = 8'd0, b = 8'd0, c = 8'd0;
   logic             d = 1'b0;
   logic             cfg_we = 1'b0;
   logic [IDX_W-1:0] cfg_idx = '0;
   logic [CYC_W-1:0] cfg_cycle = '0;
   logic [7:0]       cfg_a = 8'd0, cfg_b = 8'd0, cfg_c = 8'd0;
   logic             cfg_d = 1'b0;
   logic [NUM_W-1:0] cfg_num = '0;
   logic             start = 1'b0;
   logic             busy, done, pass;
   logic [ERR_W-1:0] err_cnt;
   logic [IDX_W-1:0] first_fail;

   int n_tests = 0;
   int n_fail  = 0;

   // Mirror of the checkpoint table and per-RUN-cycle input stimulus.
   int         m_cyc [NUM_CHK];
   logic [7:0] m_a [NUM_CHK], m_b [NUM_CHK], m_c [NUM_CHK];
   logic       m_d [NUM_CHK];
   logic [7:0] s_a [STIM_N], s_b [STIM_N], s_c [STIM_N];
   logic       s_d [STIM_N];

   out_checker #(.NUM_CHK(NUM_CHK), .CYC_W(CYC_W), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_cycle(cfg_cycle),
      .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_c(cfg_c), .cfg_d(cfg_d),
      .cfg_num(cfg_num), .start(start), .busy(busy), .done(done),
      .pass(pass), .err_cnt(err_cnt), .first_fail(first_fail)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mirror();
      for (int i = 0; i < NUM_CHK; i++) begin
         m_cyc[i] = 0; m_a[i] = 8'd0; m_b[i] = 8'd0; m_c[i] = 8'd0; m_d[i] = 1'b0;
      end
   endtask

   task automatic write_entry(input int idx, input int cy, input logic [7:0] va,
                              input logic [7:0] vb, input logic [7:0] vc, input logic vd);
      cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_cycle = CYC_W'(cy);
      cfg_a = va; cfg_b = vb; cfg_c = vc; cfg_d = vd;
      tick();
      cfg_we = 1'b0;
      m_cyc[idx] = cy; m_a[idx] = va; m_b[idx] = vb; m_c[idx] = vc; m_d[idx] = vd;
   endtask

   // Random stimulus; at each entry's compare time drive the expected values,
   // inverting each field with probability bad_pct percent.
   task automatic fill_stim(input int num, input int bad_pct);
      int t, ti;
      for (int k = 0; k < STIM_N; k++) begin
         s_a[k] = 8'($urandom); s_b[k] = 8'($urandom);
         s_c[k] = 8'($urandom); s_d[k] = 1'($urandom);
      end
      t = -1;
      for (int i = 0; i < num; i++) begin
         ti = (m_cyc[i] > t) ? m_cyc[i] : t + 1;
         s_a[ti] = ($urandom_range(0, 99) < bad_pct) ? ~m_a[i] : m_a[i];
         s_b[ti] = ($urandom_range(0, 99) < bad_pct) ? ~m_b[i] : m_b[i];
         s_c[ti] = ($urandom_range(0, 99) < bad_pct) ? ~m_c[i] : m_c[i];
         s_d[ti] = ($urandom_range(0, 99) < bad_pct) ? ~m_d[i] : m_d[i];
         t = ti;
      end
   endtask

   // Start a run, drive stimulus per RUN cycle and compare against the model.
   task automatic run_check(input string tag, input int num, input int restart_at, input int we_at);
      int t, ti, mis, err, ff, tdone, k;
      bit any;
      t = -1; err = 0; ff = 0; any = 1'b0;
      for (int i = 0; i < num; i++) begin
         ti  = (m_cyc[i] > t) ? m_cyc[i] : t + 1;
         mis = int'(s_a[ti] != m_a[i]) + int'(s_b[ti] != m_b[i])
             + int'(s_c[ti] != m_c[i]) + int'(s_d[ti] != m_d[i]);
         if (mis > 0 && !any) begin
            any = 1'b1;
            ff  = i;
         end
         err += mis;
         t = ti;
      end
      if (err > ERR_MAX) err = ERR_MAX;
      tdone = (t + 1 < 1) ? 1 : t + 1;

      cfg_num = NUM_W'(num);
      start = 1'b1;
      tick();
      k = 0;
      while (1) begin
         a = s_a[k]; b = s_b[k]; c = s_c[k]; d = s_d[k];
         start = (k == restart_at);
         if (k == we_at) begin
            cfg_we = 1'b1; cfg_idx = '0; cfg_cycle = '0;
            cfg_a = 8'hEE; cfg_b = 8'hEE; cfg_c = 8'hEE; cfg_d = 1'b1;
         end else begin
            cfg_we = 1'b0;
         end
         @(negedge clk);
         if (k == 0) begin
            check_eq({tag, "/busy0"}, busy, 1);
            check_eq({tag, "/pass_run"}, pass, 0);
         end
         if (done || k >= 150) break;
         k++;
         tick();
      end
      start = 1'b0; cfg_we = 1'b0;
      check_eq({tag, "/done_cyc"}, k, tdone);
      check_eq({tag, "/pass"}, pass, (err == 0));
      check_eq({tag, "/err_cnt"}, err_cnt, err);
      if (err != 0) check_eq({tag, "/first_fail"}, first_fail, ff);
      check_eq({tag, "/busy_done"}, busy, 0);
      tick();
      @(negedge clk);
      check_eq({tag, "/done_hold"}, done, 1);
      check_eq({tag, "/err_hold"}, err_cnt, err);
   endtask

   initial begin
      clear_mirror();
      #12;
      check_eq("rst/busy", busy, 0);
      check_eq("rst/done", done, 0);
      check_eq("rst/pass", pass, 0);
      check_eq("rst/err", err_cnt, 0);
      check_eq("rst/ff", first_fail, 0);
      tick();
      rst = 1'b1;
      tick();

      write_entry(0, 7, 8'd0, 8'd0, 8'd1, 1'b0);
      write_entry(1, 55, 8'd24, 8'd0, 8'd1, 1'b0);
      fill_stim(2, 0);
      run_check("match", 2, -1, -1);

      fill_stim(2, 0);
      s_a[55] = 8'd23;
      run_check("a23", 2, -1, -1);

      fill_stim(2, 0);
      s_a[7] = ~m_a[0]; s_b[7] = ~m_b[0]; s_c[7] = ~m_c[0]; s_d[7] = ~m_d[0];
      s_c[55] = ~m_c[1];
      run_check("err5", 2, -1, -1);

      fill_stim(0, 0);
      run_check("num0", 0, 0, -1);
      fill_stim(2, 0);
      run_check("restart_busy", 2, 3, -1);

      write_entry(0, 10, 8'h11, 8'h22, 8'h33, 1'b1);
      write_entry(1, 4, 8'h44, 8'h55, 8'h66, 1'b0);
      fill_stim(2, 0);
      run_check("late", 2, -1, 2);
      fill_stim(2, 0);
      run_check("we_run", 2, -1, -1);

      for (int i = 0; i < NUM_CHK; i++) begin
         write_entry(i, 63, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      end
      fill_stim(4, 100);
      run_check("sat", 4, -1, -1);

      fill_stim(4, 0);
      cfg_num = 3'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      rst = 1'b0;
      #1;
      check_eq("mid_rst/busy", busy, 0);
      check_eq("mid_rst/done", done, 0);
      check_eq("mid_rst/pass", pass, 0);
      check_eq("mid_rst/err", err_cnt, 0);
      check_eq("mid_rst/ff", first_fail, 0);
      clear_mirror();
      tick();
      rst = 1'b1;
      tick();
      fill_stim(4, 0);
      run_check("post_rst", 4, -1, -1);

      for (int it = 0; it < 14; it++) begin
         for (int i = 0; i < NUM_CHK; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               write_entry(i, $urandom_range(0, 63), 8'($urandom), 8'($urandom),
                           8'($urandom), 1'($urandom));
            end
         end
         fill_stim($urandom_range(0, 4), $urandom_range(0, 3) * 15);
         run_check("rnd", $urandom_range(0, 4), -1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/out_checker.md
OUT_CHECKER -- requirements
Module: out_checker

Interface
REQ-001 Parameter NUM_CHK, default 4, number of checkpoint table entries.
REQ-002 Parameter CYC_W, default 16, cycle-counter and checkpoint-cycle width.
REQ-003 Parameter ERR_W, default 8, error-counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 a, b, c  input  8 each  observed outputs of the upstream generated top.
REQ-007 d  input  1  observed 1-bit output of the upstream top.
REQ-008 cfg_we  input  1  checkpoint-table write strobe.
REQ-009 cfg_idx  input  clog2(NUM_CHK)  table entry to write.
REQ-010 cfg_cycle  input  CYC_W  cycle (relative to start) at which the entry is checked.
REQ-011 cfg_a, cfg_b, cfg_c  input  8 each, cfg_d  input  1  expected values.
REQ-012 cfg_num  input  clog2(NUM_CHK)+1  active entries, sampled on start.
REQ-013 start  input  1  one-cycle pulse; begins a check run.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  high in DONE.
REQ-016 pass  output  1  high in DONE when err_cnt == 0.
REQ-017 err_cnt  output  ERR_W  count of mismatching fields, saturating.
REQ-018 first_fail  output  clog2(NUM_CHK)  index of first failing entry; valid when err_cnt != 0.

Function
REQ-019 FSM states: IDLE, RUN, DONE; encoding free.
REQ-020 IDLE: start -> RUN; cyc, ptr, err_cnt, first_fail cleared; num latched from cfg_num.
REQ-021 First RUN cycle has cyc = 0; cyc increments by 1 per RUN cycle, saturating at all-ones.
REQ-022 Entries processed strictly in index order 0..num-1, at most one per cycle.
REQ-023 Entry ptr compared in the RUN cycle where cyc >= table[ptr].cycle; ptr then increments.
REQ-024 Each mismatching field among a, b, c, d adds 1 to err_cnt (0..4 per entry), applied at the next edge.
REQ-025 err_cnt saturates at 2^ERR_W-1; never wraps.
REQ-026 first_fail records ptr of the first entry with any mismatch; later failures do not overwrite it.
REQ-027 After compare of entry num-1, next state DONE; done rises the cycle after that compare.
REQ-028 num == 0: RUN lasts exactly one cycle with no compares, then DONE with pass = 1.
REQ-029 Non-ascending or duplicate entry cycles: late entries compared on consecutive cycles; no extra error.
REQ-030 cyc saturated with entries pending: remaining entries compared one per cycle at saturation.
REQ-031 DONE holds outputs until start; start in DONE behaves as in IDLE (restart).
REQ-032 start during RUN ignored.
REQ-033 cfg_we writes the entry at the edge in IDLE or DONE; ignored during RUN; cfg_idx >= NUM_CHK ignored.
REQ-034 pass = 0 outside DONE.

Reset
REQ-035 rst low asynchronously forces IDLE; busy, done, pass = 0; err_cnt, first_fail, cyc, ptr = 0.
REQ-036 Checkpoint table clears to all-zero on reset.
REQ-037 Reset mid-RUN aborts the run; no partial results retained.

Structure
REQ-038 Package chk_pkg holds the FSM state enum and the checkpoint-entry struct (cycle, a, b, c, d).
REQ-039 Sub-module chk_table: NUM_CHK-entry register file, one write port, one asynchronous read port indexed by ptr.
REQ-040 out_checker holds the FSM, counters, comparators and error accumulation.

Verification
REQ-041 Entries {7: a0 b0 c1 d0}, {55: a24 b0 c1 d0}, num=2, inputs matching -> done at RUN cycle 56, pass=1, err_cnt=0.
REQ-042 Same table, a=23 at cycle 55 -> err_cnt=1, first_fail=1, pass=0.
REQ-043 Entry 0 all four fields wrong, entry 1 c wrong -> err_cnt=5, first_fail=0.
REQ-044 num=0 -> done two cycles after start, pass=1; start while busy produces no restart.
REQ-045 Entries {10},{4} -> entry 1 compared at cycle 11 with no extra error; cfg_we during RUN leaves table unchanged.
REQ-046 rst low at RUN cycle 20 -> IDLE immediately, all outputs 0, table cleared; fresh start runs cleanly.
